// File: rtl/fact_host_driver.sv
// Bus-master sequencer for the factorial accelerator: write n, pulse go, poll status, read result.
// Optional poll timeout is compiled in with `define FACT_HOST_TIMEOUT_EN.
module fact_host_driver #(
  parameter int DATA_W     = 32,
  parameter int N_W        = 4,
  parameter int POLL_LIMIT = 1023
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [N_W-1:0]    req_n,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              bus_we,
  output logic [1:0]        bus_addr,
  output logic [DATA_W-1:0] bus_wd,
  input  logic [DATA_W-1:0] bus_rd
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_N   = 3'd1;
  localparam logic [2:0] S_WR_GO  = 3'd2;
  localparam logic [2:0] S_CLR_GO = 3'd3;
  localparam logic [2:0] S_POLL   = 3'd4;
  localparam logic [2:0] S_RD_RES = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic              st_done, st_err;
  logic              poll_expired;

  assign st_done = bus_rd[0];
  assign st_err  = bus_rd[1];

  // A limit below 1 gives no usable timeout window; valid limits generate nothing here.
  if (POLL_LIMIT < 1) begin : g_poll_limit_invalid
  end

`ifdef FACT_HOST_TIMEOUT_EN
  localparam int CNT_W = $clog2(POLL_LIMIT + 1);

  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;

  assign poll_expired = (poll_cnt_q == CNT_W'(POLL_LIMIT));

  // Counter stops at POLL_LIMIT instead of wrapping.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (state_q == S_CLR_GO) begin
      poll_cnt_d = '0;
    end else if (state_q == S_POLL && !poll_expired) begin
      poll_cnt_d = poll_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end
`else
  assign poll_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    result_d  = result_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          n_d     = req_n;
          state_d = S_WR_N;
        end
      end
      S_WR_N:   state_d = S_WR_GO;
      S_WR_GO:  state_d = S_CLR_GO;
      S_CLR_GO: state_d = S_POLL;
      S_POLL: begin
        // Error outranks done, and any status outranks the timeout.
        if (st_err) begin
          err_d     = 1'b1;
          result_d  = '0;
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else if (st_done) begin
          state_d = S_RD_RES;
        end else if (poll_expired) begin
          timeout_d = 1'b1;
          err_d     = 1'b0;
          result_d  = '0;
          state_d   = S_RESP;
        end
      end
      S_RD_RES: begin
        result_d  = bus_rd;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      result_q  <= result_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  // Bus signals depend on state and the latched operand only, never on bus_rd.
  always_comb begin
    bus_we   = 1'b0;
    bus_addr = 2'd0;
    bus_wd   = '0;
    case (state_q)
      S_WR_N: begin
        bus_we   = 1'b1;
        bus_addr = 2'd0;
        bus_wd   = DATA_W'(n_q);
      end
      S_WR_GO: begin
        bus_we   = 1'b1;
        bus_addr = 2'd1;
        bus_wd   = DATA_W'(1);
      end
      S_CLR_GO: begin
        bus_we   = 1'b1;
        bus_addr = 2'd1;
      end
      S_POLL:   bus_addr = 2'd2;
      S_RD_RES: bus_addr = 2'd3;
      default: ;
    endcase
  end

  assign req_ready   = (state_q == S_IDLE) && !rst;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_result  = result_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fact_host_driver.sv
// Directed bench for fact_host_driver with a behavioural accelerator bus model and a response scoreboard.
// Build with +define+FACT_HOST_TIMEOUT_EN to exercise the poll timeout path.
module tb_fact_host_driver;
  localparam int DATA_W     = 32;
  localparam int N_W        = 4;
  localparam int POLL_LIMIT = 8;

  logic              CLK = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [N_W-1:0]    req_n = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              bus_we;
  logic [1:0]        bus_addr;
  logic [DATA_W-1:0] bus_wd;
  logic [DATA_W-1:0] bus_rd;

  fact_host_driver #(.DATA_W(DATA_W), .N_W(N_W), .POLL_LIMIT(POLL_LIMIT)) dut (
    .CLK(CLK), .rst(rst),
    .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_rd(bus_rd)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Accelerator model: configured by the stimulus, armed by the go pulse.
  int                m_delay  = 0;
  logic              m_err    = 1'b0;
  logic              m_never  = 1'b0;
  logic [DATA_W-1:0] m_result = '0;
  logic              m_armed  = 1'b0;
  int                m_cnt    = 0;
  logic              m_ready;

  assign m_ready = m_armed && !m_never && (m_cnt >= m_delay);

  always_comb begin
    case (bus_addr)
      2'd2:    bus_rd = {30'd0, m_ready && m_err, m_ready};
      2'd3:    bus_rd = m_result;
      default: bus_rd = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      m_armed <= 1'b0;
      m_cnt   <= 0;
    end else if (bus_we && bus_addr == 2'd0) begin
      m_armed <= 1'b0;
    end else if (bus_we && bus_addr == 2'd1 && bus_wd == 32'd1) begin
      m_armed <= 1'b1;
      m_cnt   <= 0;
    end else if (m_armed) begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Bus activity log, read-only from the stimulus side.
  logic [1:0]        wr_addr [256];
  logic [DATA_W-1:0] wr_data [256];
  int                wr_cnt    = 0;
  int                rd3_cnt   = 0;
  int                done_edge = 0;

  always @(posedge CLK) begin
    if (!rst && bus_we && wr_cnt < 256) begin
      wr_addr[wr_cnt] <= bus_addr;
      wr_data[wr_cnt] <= bus_wd;
      wr_cnt          <= wr_cnt + 1;
    end
    if (!rst && !bus_we && bus_addr == 2'd3) rd3_cnt <= rd3_cnt + 1;
    if (!rst && !bus_we && bus_addr == 2'd2 && bus_rd[0]) done_edge <= cyc + 1;
  end

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              err;
    logic              to;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns the edge index k at which the request was accepted.
  task automatic send(input logic [N_W-1:0] n, output int k);
    bit acc;
    acc = 1'b0;
    k = -1;
    req_valid = 1'b1;
    req_n = n;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = req_ready;
      k = cyc + 1;
      @(negedge CLK);
    end
    req_valid = 1'b0;
    req_n = ~n;
    chk("req_accepted", acc, 1);
  endtask

  // Returns the cycle index (interval ending at edge rc) in which rsp_valid is first seen.
  task automatic wait_rsp(input string tag, output int rc);
    bit got;
    got = 1'b0;
    rc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        rc = cyc + 1;
      end else begin
        @(negedge CLK);
      end
    end
    chk({tag, "_rsp_seen"}, got, 1);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, rsp_result, e.res);
      chk({tag, "_err"}, rsp_err, e.err);
      chk({tag, "_timeout"}, rsp_timeout, e.to);
    end
    $display("[TB] %s response result=%0d err=%0b timeout=%0b", tag, rsp_result, rsp_err, rsp_timeout);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk({tag, "_valid_dropped"}, rsp_valid, 0);
    chk({tag, "_req_ready_back"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rc, pc, w0, r0, cnt;
    bit found;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wd", bus_wd, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    @(negedge CLK);

    // T1: n=5, done 10 cycles after go, result 120
    m_delay = 10; m_err = 1'b0; m_never = 1'b0; m_result = 120;
    sb.push_back('{res: 32'd120, err: 1'b0, to: 1'b0});
    w0 = wr_cnt;
    send(4'd5, k);
    wait_rsp("t1", rc);
    chk("t1_wr_count", wr_cnt - w0, 3);
    chk("t1_wr0", {wr_addr[w0], wr_data[w0]}, {2'd0, 32'd5});
    chk("t1_wr1", {wr_addr[w0+1], wr_data[w0+1]}, {2'd1, 32'd1});
    chk("t1_wr2", {wr_addr[w0+2], wr_data[w0+2]}, {2'd1, 32'd0});
    chk("t1_done_to_valid", rc - done_edge, 2);
    collect("t1");

    // T2: n=0, immediate done, result 1
    m_delay = 0; m_result = 1;
    sb.push_back('{res: 32'd1, err: 1'b0, to: 1'b0});
    send(4'd0, k);
    chk("t2_wr_n_we", bus_we, 1);
    chk("t2_wr_n_wd", bus_wd, 0);
    found = 1'b0;
    pc = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!bus_we && bus_addr == 2'd2) begin
        found = 1'b1;
        pc = cyc + 1;
      end else begin
        @(negedge CLK);
      end
    end
    chk("t2_first_poll", pc - k, 4);
    wait_rsp("t2", rc);
    chk("t2_rsp_cycle", rc - k, 6);
    collect("t2");

    // T3: n=13, err and done together
    m_delay = 2; m_err = 1'b1; m_result = 32'h1234_5678;
    sb.push_back('{res: 32'd0, err: 1'b1, to: 1'b0});
    r0 = rd3_cnt;
    send(4'd13, k);
    wait_rsp("t3", rc);
    chk("t3_no_result_read", rd3_cnt - r0, 0);
    collect("t3");

    // T4: n=4, result 24, consumer stalls 5 cycles; second request waits for IDLE
    m_delay = 4; m_err = 1'b0; m_result = 24;
    sb.push_back('{res: 32'd24, err: 1'b0, to: 1'b0});
    send(4'd4, k);
    wait_rsp("t4a", rc);
    req_valid = 1'b1;
    req_n = 4'd7;
    sb.push_back('{res: 32'd5040, err: 1'b0, to: 1'b0});
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_result", rsp_result, 24);
      chk("t4_hold_req_ready", req_ready, 0);
      @(negedge CLK);
    end
    m_result = 5040;
    collect("t4a");
    @(negedge CLK);
    chk("t4b_accept_we", bus_we, 1);
    chk("t4b_accept_addr", bus_addr, 0);
    chk("t4b_accept_wd", bus_wd, 7);
    req_valid = 1'b0;
    req_n = 4'd2;
    wait_rsp("t4b", rc);
    collect("t4b");

    // T5: asynchronous reset mid-POLL, then n=3 completes
    m_never = 1'b1;
    send(4'd9, k);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!bus_we && bus_addr == 2'd2) found = 1'b1;
      else @(negedge CLK);
    end
    chk("t5_reached_poll", found, 1);
    @(negedge CLK);
    @(posedge CLK);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_bus_we", bus_we, 0);
    chk("t5_async_bus_addr", bus_addr, 0);
    chk("t5_async_rsp_valid", rsp_valid, 0);
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    #1;
    chk("t5_req_ready", req_ready, 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (rsp_valid || bus_we) cnt++;
    end
    chk("t5_no_activity", cnt, 0);
    $display("[TB] t5 aborted request n=9 by reset");
    m_never = 1'b0; m_delay = 3; m_result = 6;
    sb.push_back('{res: 32'd6, err: 1'b0, to: 1'b0});
    send(4'd3, k);
    wait_rsp("t5", rc);
    collect("t5");

    // T6: done never asserted
    m_never = 1'b1;
`ifdef FACT_HOST_TIMEOUT_EN
    sb.push_back('{res: 32'd0, err: 1'b0, to: 1'b1});
    send(4'd6, k);
    cnt = 0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      if (!bus_we && bus_addr == 2'd2) cnt++;
      @(negedge CLK);
    end
    chk("t6_poll_cycles", cnt, POLL_LIMIT + 1);
    wait_rsp("t6", rc);
    collect("t6");
`else
    send(4'd6, k);
    repeat (40) @(negedge CLK);
    chk("t6_still_poll_addr", bus_addr, 2);
    chk("t6_still_poll_we", bus_we, 0);
    chk("t6_no_rsp", rsp_valid, 0);
    chk("t6_no_timeout", rsp_timeout, 0);
    $display("[TB] t6 request n=6 still polling after 40 cycles");
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
`endif
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
